// File: rtl/fifo_rd_drain_pkg.sv
// rtl/fifo_rd_drain_pkg.sv - shared constants, state type and pointer helper for the read drain
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 3;
    localparam int ADDR_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        STALL
    } drain_state_t;

    // Circular pointer step over a non-power-of-two depth
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_drain_if.sv
// rtl/fifo_rd_drain_if.sv - FIFO read port and output stream bundle for the read drain
interface fifo_rd_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  empty;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_enb;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        input  empty,
        input  rd_data,
        input  out_ready,
        output rd_enb,
        output out_valid,
        output out_data,
        output out_last
    );

    modport slave (
        output empty,
        output rd_data,
        output out_ready,
        input  rd_enb,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/fifo_rd_drain_skid_buf.sv
// rtl/fifo_rd_drain_skid_buf.sv - 3-entry circular buffer absorbing the FIFO read latency
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] count,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;

    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({push, pop})
                2'b10:   count <= count + ADDR_WIDTH'(1);
                2'b01:   count <= count - ADDR_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // Upstream gating must make these unreachable
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= ADDR_WIDTH'(DEPTH));
            assert (!(push && !pop && count == ADDR_WIDTH'(DEPTH)));
        end
    end

endmodule

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - read-side drain: gated FIFO reads, skid buffer, burst marker and counters
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 rd_clk,
    input  logic                 rst,
    input  logic                 en,
    fifo_rd_drain_if.master      bus,
    output logic [CNT_WIDTH-1:0] word_cnt,
    output logic                 idle,
    output drain_state_t         state
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

    logic                  inflight;
    logic [ADDR_WIDTH-1:0] count;
    logic [ADDR_WIDTH:0]   occupancy;
    logic                  pop;
    logic [BEAT_W-1:0]     beat;
    logic [ADDR_WIDTH:0]   cnt_n;
    logic [ADDR_WIDTH:0]   occ_n;
    drain_state_t          state_d;

    // Only registered terms decide a read, so out_ready never reaches rd_enb
    assign occupancy     = {1'b0, count} + {{ADDR_WIDTH{1'b0}}, inflight};
    assign bus.rd_enb    = !rst && en && !bus.empty && (occupancy < (ADDR_WIDTH+1)'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_last  = bus.out_valid && (beat == BEAT_MAX);
    assign idle          = (count == '0) && !inflight;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk       (rd_clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.rd_data),
        .pop       (pop),
        .count     (count),
        .head_data (bus.out_data)
    );

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            inflight <= 1'b0;
            beat     <= '0;
            word_cnt <= '0;
        end else begin
            inflight <= bus.rd_enb;
            if (pop) begin
                beat     <= (beat == BEAT_MAX) ? '0 : beat + BEAT_W'(1);
                word_cnt <= word_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // State mirrors the occupancy the buffer will hold after this edge
    always_comb begin
        cnt_n   = {1'b0, count} + {{ADDR_WIDTH{1'b0}}, inflight} - {{ADDR_WIDTH{1'b0}}, pop};
        occ_n   = cnt_n + {{ADDR_WIDTH{1'b0}}, bus.rd_enb};
        state_d = IDLE;
        if (cnt_n == '0) begin
            state_d = bus.rd_enb ? FILL : IDLE;
        end else if (occ_n >= (ADDR_WIDTH+1)'(DEPTH)) begin
            state_d = STALL;
        end else begin
            state_d = STREAM;
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - self-checking bench for fifo_rd_drain
module tb_fifo_rd_drain;
    import fifo_pkg::*;

    localparam int DW = 8;
    localparam int BL = 4;
    localparam int CW = 16;

    logic          rd_clk = 1'b0;
    logic          rst;
    logic          en;
    logic [CW-1:0] word_cnt;
    logic          idle;
    drain_state_t  state;

    fifo_rd_drain_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_drain #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .CNT_WIDTH  (CW)
    ) dut (
        .rd_clk   (rd_clk),
        .rst      (rst),
        .en       (en),
        .bus      (bus),
        .word_cnt (word_cnt),
        .idle     (idle),
        .state    (state)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct {
        int n_words;
        int base;
        int ready_pct;
        int gap_pct;
        int exp_beats;
        int exp_lasts;
    } vec_t;

    vec_t          vecs [6];
    logic [DW-1:0] src [$];
    logic [DW-1:0] exp_q [$];
    int            outstanding, accepted, beats, delivered, lasts;
    bit            inflight_m, hold_pending, force_empty;
    logic [DW-1:0] held;
    int            checks, errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic drain_state_t exp_state(input int cnt, input bit inf);
        if (cnt == 0) return inf ? FILL : IDLE;
        if (cnt + int'(inf) >= 3) return STALL;
        return STREAM;
    endfunction

    // One clock: sample and score at negedge, then advance the model past the edge
    task automatic tick();
        logic [DW-1:0] w;
        bit            enb_s, acc;
        int            cnt;
        w = '0;
        acc = 1'b0;
        bus.empty = (src.size() == 0) || force_empty;
        @(negedge rd_clk);
        enb_s = bus.rd_enb;
        cnt   = outstanding - int'(inflight_m);
        check("rd_enb", bus.rd_enb, !rst && en && !bus.empty && outstanding < 3);
        if (!rst) begin
            check("out_valid", bus.out_valid, cnt != 0);
            check("out_last", bus.out_last, cnt != 0 && (beats % BL) == BL - 1);
            check("idle", idle, outstanding == 0);
            check("word_cnt", word_cnt, accepted % (1 << CW));
            check("state", state, exp_state(cnt, inflight_m));
            if (hold_pending) check("hold", bus.out_data, held);
            acc = (cnt != 0) && bus.out_ready;
            if (acc) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data: got %0h with no word expected", bus.out_data);
                end else begin
                    check("data", bus.out_data, exp_q.pop_front());
                end
                delivered++;
                if (bus.out_last) lasts++;
            end
            hold_pending = (cnt != 0) && !bus.out_ready;
            held = bus.out_data;
        end else begin
            hold_pending = 1'b0;
        end
        if (enb_s) begin
            w = (src.size() > 0) ? src.pop_front() : DW'($urandom);
            exp_q.push_back(w);
        end
        @(posedge rd_clk);
        #1;
        if (rst) begin
            outstanding = 0;
            inflight_m  = 1'b0;
            accepted    = 0;
            beats       = 0;
            delivered   = 0;
            lasts       = 0;
            exp_q.delete();
        end else begin
            outstanding += int'(enb_s) - int'(acc);
            inflight_m  = enb_s;
            if (acc) begin
                accepted++;
                beats++;
            end
        end
        bus.rd_data = enb_s ? w : DW'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        bus.out_ready = 1'b0;
        force_empty = 1'b0;
        src.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) src.push_back((base != 0) ? DW'(base + i) : DW'($urandom));
    endtask

    task automatic run_drain(input int ready_pct, input int gap_pct, input int budget);
        int cyc;
        cyc = 0;
        while ((src.size() != 0 || outstanding != 0) && cyc < budget) begin
            bus.out_ready = ($urandom_range(0, 99) < ready_pct);
            force_empty = ($urandom_range(0, 99) < gap_pct);
            tick();
            cyc++;
        end
        force_empty = 1'b0;
        if (cyc >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words left after %0d cycles", src.size() + outstanding, cyc);
        end
    endtask

    task automatic wait_delivered(input int n, input int budget);
        int cyc;
        cyc = 0;
        while (delivered < n && cyc < budget) begin
            tick();
            cyc++;
        end
        if (cyc >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: delivered %0d required %0d", delivered, n);
        end
    endtask

    initial begin
        int rem, cyc;
        checks = 0;
        errors = 0;
        outstanding = 0;
        accepted = 0;
        beats = 0;
        delivered = 0;
        lasts = 0;
        inflight_m = 1'b0;
        hold_pending = 1'b0;
        bus.rd_data = '0;
        bus.empty = 1'b1;

        vecs[0] = '{8,  1,    100, 0,  8,  2};
        vecs[1] = '{8,  8'h20, 40, 0,  8,  2};
        vecs[2] = '{2,  8'h40, 100, 0, 2,  0};
        vecs[3] = '{6,  0,    70,  30, 6,  1};
        vecs[4] = '{13, 0,    50,  20, 13, 3};
        vecs[5] = '{4,  8'h80, 100, 50, 4,  1};

        // Reset then idle
        do_reset();
        check("rst_rd_enb", bus.rd_enb, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_idle", idle, 1'b1);
        check("rst_word_cnt", word_cnt, 0);

        // Table vectors
        for (int v = 0; v < 6; v++) begin
            do_reset();
            load(vecs[v].n_words, vecs[v].base);
            en = 1'b1;
            run_drain(vecs[v].ready_pct, vecs[v].gap_pct, 400);
            repeat (2) tick();
            check($sformatf("vec%0d_beats", v), delivered, vecs[v].exp_beats);
            check($sformatf("vec%0d_lasts", v), lasts, vecs[v].exp_lasts);
            check($sformatf("vec%0d_word_cnt", v), word_cnt, vecs[v].exp_beats);
            check($sformatf("vec%0d_idle", v), idle, 1'b1);
        end

        // Backpressure after the first word
        do_reset();
        load(8, 8'h10);
        en = 1'b1;
        bus.out_ready = 1'b1;
        wait_delivered(1, 20);
        bus.out_ready = 1'b0;
        repeat (8) tick();
        check("bp_state", state, STALL);
        check("bp_rd_enb", bus.rd_enb, 1'b0);
        check("bp_delivered", delivered, 1);
        run_drain(100, 0, 100);
        check("bp_total", delivered, 8);

        // en dropped with two buffered and one in flight
        do_reset();
        load(10, 8'h50);
        en = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("en0_state", state, STALL);
        en = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) tick();
        check("en0_delivered", delivered, 3);
        check("en0_src_left", src.size(), 7);
        check("en0_idle", idle, 1'b1);
        en = 1'b1;
        run_drain(100, 0, 100);
        check("en0_total", delivered, 10);

        // Reset mid-burst with count=2, inflight=1
        do_reset();
        load(12, 8'h60);
        en = 1'b1;
        bus.out_ready = 1'b1;
        wait_delivered(2, 20);
        bus.out_ready = 1'b0;
        cyc = 0;
        while (!(outstanding == 3 && inflight_m) && cyc < 10) begin
            tick();
            cyc++;
        end
        check("mid_reached", outstanding == 3 && inflight_m, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_out_valid", bus.out_valid, 1'b0);
        check("mid_word_cnt", word_cnt, 0);
        check("mid_idle", idle, 1'b1);
        rem = src.size();
        run_drain(100, 0, 100);
        check("mid_beats", delivered, rem);
        check("mid_lasts", lasts, rem / BL);

        // Long randomized soak against the model
        do_reset();
        load(200, 0);
        en = 1'b1;
        run_drain(60, 25, 2000);
        check("soak_beats", delivered, 200);
        check("soak_lasts", lasts, 200 / BL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
